// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port synchronous memory between the core and an auxiliary master.
// Defining CPU_MEM_ARB_STATS_EN adds a saturating stall_count output.

module cpu_mem_arbiter #(
   parameter int DMA_GAP = 5
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wmask,
   output logic [31:0] cpu_rdata,
   output logic        cpu_hold,

   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [3:0]  dma_wmask,
   output logic        dma_ack,
   output logic [31:0] dma_rdata,

   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,

`ifdef CPU_MEM_ARB_STATS_EN
   output logic [15:0] stall_count,
`endif
   output logic [1:0]  dbg_state
);

   // Handshake: dma_req is a level request held with stable addr/data/mask until
   // dma_ack; dma_ack is a one-cycle pulse and dma_rdata is meaningful only then.
   // The core has no request line; cpu_hold stalls it while the auxiliary master owns the bus.

   localparam logic [1:0] ST_CPU   = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;

   localparam int              GAP_W    = (DMA_GAP > 0) ? $clog2(DMA_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DMA_GAP);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [GAP_W-1:0] gap_cnt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CPU:   if (dma_req && (gap_cnt == '0)) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_DATA;
         ST_DATA:  state_nxt = ST_CPU;
         default:  state_nxt = ST_CPU;
      endcase
   end

   // gap_cnt only moves in CPU (countdown) and DATA (reload); GRANT leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CPU;
         gap_cnt <= GAP_LOAD;
      end else begin
         state <= state_nxt;
         case (state)
            ST_CPU:  if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            ST_DATA: gap_cnt <= GAP_LOAD;
            default: gap_cnt <= gap_cnt;
         endcase
      end
   end

   // DATA re-presents the stalled core address so the core's in-flight read is
   // valid on release; its store stays pending rather than being replayed here.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wmask = cpu_wmask;
      cpu_hold  = 1'b0;
      dma_ack   = 1'b0;
      case (state)
         ST_GRANT: begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_wmask = dma_wmask;
            cpu_hold  = 1'b1;
         end
         ST_DATA: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wmask = 4'b0000;
            cpu_hold  = 1'b1;
            dma_ack   = 1'b1;
         end
         default: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wmask = cpu_wmask;
         end
      endcase
   end

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;
   assign dbg_state = state;

`ifdef CPU_MEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= 16'h0000;
      end else if (cpu_hold && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed bench with a behavioural 1-cycle-latency memory and an ack scoreboard.
// Build with CPU_MEM_ARB_STATS_EN defined to also check stall_count.

module tb_cpu_mem_arbiter;

   localparam int DMA_GAP = 5;

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_wmask;
   logic        cpu_hold;
   logic        dma_req, dma_ack;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [3:0]  dma_wmask;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic [1:0]  dbg_state;
`ifdef CPU_MEM_ARB_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] stall_base;
`endif

   always #5 clk = ~clk;

   cpu_mem_arbiter #(.DMA_GAP(DMA_GAP)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
      .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_wmask(dma_wmask), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata),
`ifdef CPU_MEM_ARB_STATS_EN
      .stall_count(stall_count),
`endif
      .dbg_state(dbg_state)
   );

   // Synchronous memory: read data for the previous cycle's address, byte-masked write on the edge.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
         if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic        exp_rd_q[$];
   logic [31:0] mon_exp;
   logic        mon_rd;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && dma_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dma_ack_unexpected: got ack with nothing outstanding, required no ack");
         end else begin
            mon_exp = exp_q.pop_front();
            mon_rd  = exp_rd_q.pop_front();
            if (mon_rd) check32("dma_rdata", dma_rdata, mon_exp);
         end
      end
   end

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dma_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [31:0] exp_rdata,
                           input int exp_lat, output int hold_n);
      int lat;
      bit done;
      dma_req   = 1'b1;
      dma_addr  = addr;
      dma_wdata = wdata;
      dma_wmask = wmask;
      exp_q.push_back(exp_rdata);
      exp_rd_q.push_back(wmask == 4'h0);
      lat    = 0;
      hold_n = 0;
      done   = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (cpu_hold) hold_n++;
         if (dma_ack) begin
            check32("data_mem_addr_restore", mem_addr, cpu_addr);
            check32("data_mem_wmask_zero", 32'(mem_wmask), 32'h0);
            done = 1'b1;
         end else begin
            if (cpu_hold) begin
               check32("grant_mem_addr", mem_addr, addr);
               check32("grant_mem_wmask", 32'(mem_wmask), 32'(wmask));
            end
            lat++;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL dma_ack_timeout: got no ack in 64 cycles, required ack");
      end else begin
         check32("dma_latency", 32'(lat), 32'(exp_lat));
      end
      tick();
      dma_req   = 1'b0;
      dma_wmask = 4'h0;
   endtask

   // ---------------- stimulus ----------------
   int hold_n, acks, last, hold_tot, cnt;
   bit found;

   initial begin
      reset = 1'b1;
      cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
      dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wmask = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1234_5678; cpu_wmask = 4'h0;
      @(negedge clk);
      check32("rst_hold", 32'(cpu_hold), 32'h0);
      check32("rst_ack", 32'(dma_ack), 32'h0);
      check32("rst_state", 32'(dbg_state), 32'h0);
      check32("rst_mem_addr", mem_addr, 32'h0000_0040);
      check32("rst_mem_wdata", mem_wdata, 32'h1234_5678);
      tick();
      reset = 1'b0;

      // Idle: core owns the bus, stores pass straight through
      cpu_addr = 32'h0001_0074; cpu_wdata = 32'h00A0_0093; cpu_wmask = 4'hF;
      @(negedge clk);
      check32("idle_store_mask", 32'(mem_wmask), 32'hF);
      for (int i = 0; i < 40; i++) begin
         tick();
         cpu_addr  = 32'h300 + 32'(i * 4);
         cpu_wdata = {16'hA5A5, 16'(i)};
         cpu_wmask = (i % 3 == 0) ? 4'hF : 4'h0;
         @(negedge clk);
         check32("idle_mem_addr", mem_addr, cpu_addr);
         check32("idle_mem_wdata", mem_wdata, cpu_wdata);
         check32("idle_mem_wmask", 32'(mem_wmask), 32'(cpu_wmask));
         check32("idle_hold", 32'(cpu_hold), 32'h0);
         check32("idle_ack", 32'(dma_ack), 32'h0);
      end
      tick();
      cpu_wmask = 4'h0;
      check32("idle_mem_300", mem[192], 32'hA5A5_0000);
      check32("idle_mem_074", mem[29], 32'h00A0_0093);

      // DMA write of DEADBEEF to 0x100
      dma_xfer(32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 2, hold_n);
      check32("wr_hold_cycles", 32'(hold_n), 32'd2);
      @(negedge clk);
      check32("wr_hold_released", 32'(cpu_hold), 32'h0);
      check32("wr_mem_100", mem[64], 32'hDEAD_BEEF);

      // Fetch from 0x10074 issued in the cycle just before a DMA read grant
      repeat (8) tick();
      cpu_addr = 32'h0001_0074; cpu_wmask = 4'h0;
      dma_xfer(32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, hold_n);
      @(negedge clk);
      check32("fetch_hold_released", 32'(cpu_hold), 32'h0);
      check32("fetch_restored_rdata", cpu_rdata, 32'h00A0_0093);

      // Collision: core store to 0x200 raised while DMA write to 0x200 is granted
      repeat (8) tick();
      cpu_addr = 32'h40; cpu_wmask = 4'h0;
      dma_req = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h2222_2222; dma_wmask = 4'hF;
      exp_q.push_back(32'h0); exp_rd_q.push_back(1'b0);
      @(negedge clk);
      check32("col_c0_hold", 32'(cpu_hold), 32'h0);
      tick();
      cpu_addr = 32'h200; cpu_wdata = 32'h1111_1111; cpu_wmask = 4'hF;
      @(negedge clk);
      check32("col_grant_hold", 32'(cpu_hold), 32'h1);
      check32("col_grant_wdata", mem_wdata, 32'h2222_2222);
      tick();
      @(negedge clk);
      check32("col_data_ack", 32'(dma_ack), 32'h1);
      check32("col_data_wmask", 32'(mem_wmask), 32'h0);
      check32("col_mem_after_dma", mem[128], 32'h2222_2222);
      tick();
      dma_req = 1'b0; dma_wmask = 4'h0;
      @(negedge clk);
      check32("col_cpu_hold", 32'(cpu_hold), 32'h0);
      check32("col_cpu_wmask", 32'(mem_wmask), 32'hF);
      check32("col_cpu_wdata", mem_wdata, 32'h1111_1111);
      check32("col_mem_before_cpu", mem[128], 32'h2222_2222);
      tick();
      cpu_wmask = 4'h0;
      check32("col_mem_final", mem[128], 32'h1111_1111);

      // Continuous request: ack every 8 cycles, 2 hold cycles per transfer
      repeat (8) tick();
      cpu_addr = 32'h40;
`ifdef CPU_MEM_ARB_STATS_EN
      stall_base = stall_count;
`endif
      for (int k = 0; k < 10; k++) begin
         exp_q.push_back(32'hDEAD_BEEF);
         exp_rd_q.push_back(1'b1);
      end
      dma_req = 1'b1; dma_addr = 32'h100; dma_wmask = 4'h0;
      acks = 0; last = 0; hold_tot = 0;
      for (int c = 0; c < 200 && acks < 10; c++) begin
         @(negedge clk);
         if (cpu_hold) hold_tot++;
         if (dma_ack) begin
            if (acks > 0) check32("cont_ack_period", 32'(c - last), 32'd8);
            last = c;
            acks++;
         end
      end
      if (acks != 10) begin
         n_checks++;
         n_fail++;
         $display("FAIL cont_timeout: got %0d acks, required 10", acks);
      end
      tick();
      dma_req = 1'b0;
      check32("cont_hold_cycles", 32'(hold_tot), 32'd20);
`ifdef CPU_MEM_ARB_STATS_EN
      check32("stall_count_delta", 32'(stall_count - stall_base), 32'd20);
`endif

      // Reset asserted during GRANT: aborted request is re-granted later
      repeat (8) tick();
      exp_q.push_back(32'hDEAD_BEEF); exp_rd_q.push_back(1'b1);
      dma_req = 1'b1; dma_addr = 32'h100; dma_wmask = 4'h0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check32("rstg_grant_hold", 32'(cpu_hold), 32'h1);
      check32("rstg_grant_ack", 32'(dma_ack), 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check32("rstg_hold", 32'(cpu_hold), 32'h0);
      check32("rstg_ack", 32'(dma_ack), 32'h0);
      check32("rstg_state", 32'(dbg_state), 32'h0);
`ifdef CPU_MEM_ARB_STATS_EN
      check32("rstg_stall_count", 32'(stall_count), 32'h0);
`endif
      cnt = 1;
      found = dma_ack;
      for (int c = 0; c < 32 && !found; c++) begin
         tick();
         @(negedge clk);
         cnt++;
         found = dma_ack;
      end
      if (found) begin
         check32("rstg_regrant_latency", 32'(cnt), 32'd8);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL rstg_timeout: got no ack in 32 cycles, required ack");
      end
      tick();
      dma_req = 1'b0;

      repeat (3) tick();
      check32("exp_q_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Two-master arbiter that shares the single-port, word-wide memory between the RV32I core and an auxiliary bus master (DMA / debug loader). The core has no request line, so the arbiter takes the bus by asserting the core's `hold`. Before releasing `hold`, it re-presents the core's stalled address so the core's in-flight read returns correct data. It sits between the core's memory port and the synchronous memory, which has 1-cycle read latency and commits byte-masked writes on the clock edge.

## Interface
Parameters:
- `DMA_GAP`, default 5: minimum extra core-owned cycles between two auxiliary grants (starvation guard).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cpu_addr` in 32: core memory address.
- `cpu_wdata` in 32: core store data.
- `cpu_wmask` in 4: core byte write mask.
- `cpu_rdata` out 32: read data to core; direct copy of `mem_rdata`.
- `cpu_hold` out 1: stall to core.
- `dma_req` in 1: auxiliary request. Held high with stable addr/data/mask until `dma_ack`.
- `dma_addr` in 32: auxiliary word address.
- `dma_wdata` in 32: auxiliary write data.
- `dma_wmask` in 4: auxiliary byte mask. 0 means read.
- `dma_ack` out 1: one-cycle completion pulse.
- `dma_rdata` out 32: copy of `mem_rdata`; valid only while `dma_ack`=1.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wmask` out 4: memory byte write mask.
- `mem_rdata` in 32: memory read data; returns the address from the previous cycle.

## Operation
States, encoded in a register:
- CPU: core owns the bus.
  - `mem_*` = `cpu_*`, `cpu_hold`=0, `dma_ack`=0.
  - Goes to GRANT when `dma_req`=1 and `gap_cnt`=0. Otherwise stays in CPU.
- GRANT: auxiliary master owns the bus.
  - `mem_addr`/`mem_wdata`/`mem_wmask` = `dma_*`, `cpu_hold`=1.
  - The core's mask is gated off the memory.
  - Always goes to DATA.
- DATA: auxiliary transfer completes.
  - `dma_ack`=1, `cpu_hold`=1.
  - `dma_rdata` holds the result of the GRANT-cycle read.
  - `mem_addr`=`cpu_addr` (restore), `mem_wmask`=0. The core's store is never replayed here.
  - Always goes to CPU. Loads `gap_cnt` with `DMA_GAP`.

Rules:
- `gap_cnt` decrements at the end of each CPU-state cycle while it is nonzero. It is never modified in GRANT or DATA.
- Every core store is committed in a CPU-state cycle. A core mask raised during GRANT/DATA stays pending and commits in the first CPU cycle after DATA.
- A drop of `dma_req` before the grant cancels the request silently. Deasserting it during GRANT is a protocol violation; the transfer still completes.

## Timing
- Reset values:
  - state=CPU, `gap_cnt`=`DMA_GAP`.
  - `cpu_hold`=0, `dma_ack`=0.
  - `mem_*` follow `cpu_*`.
- All outputs decode combinationally from the state register. `cpu_rdata`/`dma_rdata` are plain wires.
- Request latency: `dma_req` is sampled at the end of a CPU cycle. GRANT follows in the next cycle, and `dma_ack` one cycle after that. Minimum `dma_req`-to-`dma_ack` latency is 2 cycles.
- `cpu_hold` is high for exactly 2 cycles (GRANT, DATA) per auxiliary transfer.
- The core gets at least `DMA_GAP`+1 consecutive CPU-state cycles between grants. With `DMA_GAP`=0 it still gets 1 cycle.
- Under continuous `dma_req`, the grant period is `DMA_GAP`+3 cycles.
- The cycle after DATA presents `mem_rdata` = mem[`cpu_addr`], so a fetch or load interrupted mid-flight reads correctly.
- Reset in GRANT or DATA: state returns to CPU next cycle. No ack is issued for the aborted request. A still-asserted request is re-granted after `DMA_GAP`+1 cycles.

## Configuration
- `CPU_MEM_ARB_STATS_EN` defined:
  - Adds output `stall_count`, 16 bits.
  - Counts cycles with `cpu_hold`=1.
  - Saturates at 16'hFFFF and clears on reset.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

## Test plan
- Idle: `dma_req`=0 for 200 cycles while the core runs a program. `cpu_hold` stays 0, `mem_*` always equal `cpu_*`, and the program produces the reference register results.
- DMA write: 32'hDEADBEEF to 32'h100, mask 4'b1111. `dma_ack` asserts 2 cycles after `dma_req`, mem[32'h100]=32'hDEADBEEF, and `cpu_hold` is high for exactly 2 cycles.
- DMA read in the cycle after the core issues a fetch from 32'h10074. The core latches the correct instruction. The following DMA read of 32'h100 returns 32'hDEADBEEF.
- Collision: the core's store of 32'h11111111 to 32'h200 is pending when a DMA write of 32'h22222222 to 32'h200 is granted. The core store commits once, after the DMA write, leaving mem[32'h200]=32'h11111111.
- Continuous `dma_req` with `DMA_GAP`=5. Acks occur every 8 cycles and each hold window is 2 cycles. With `CPU_MEM_ARB_STATS_EN`, `stall_count`=20 after 10 acks.
- Reset asserted during GRANT: the next cycle shows `cpu_hold`=0 and `dma_ack`=0, and `gap_cnt` is reloaded. The held request is acked 8 cycles after reset deasserts.
